frame_rx_10b: RTL and testbench

Frame receiver that sits directly downstream of the 10-bit serial-in/parallel-out shift register. It watches the serial line, counts bits, and delineates 10-bit frames: start bit 0, 8 data bits LSB first, stop bit 1. When a full frame is in the shift register it validates the frame, then pushes the data byte into a small FIFO drained through a valid/ready handshake. It also flags framing errors, breaks and overruns.

---
 rtl/frame_rx_pkg.sv | 36 +++
 rtl/frame_rx_10b_if.sv | 11 +
 rtl/frame_rx_fifo.sv | 69 ++++++
 rtl/frame_rx_10b.sv | 163 ++++++++++++++++
 tb/tb_frame_rx_10b.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_rx_pkg.sv
// Shared types and constants for the 10-bit frame receiver.
package frame_rx_pkg;

  localparam int          FRAME_BITS = 10;
  localparam int          DATA_BITS  = 8;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  // Counter value at which the last frame bit is being shifted in.
  localparam logic [3:0]  CNT_LAST   = 4'd9;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    FR_OK  = 2'd0,
    FR_BAD = 2'd1,
    FR_BRK = 2'd2
  } frame_kind_e;

  // Classify a complete frame as held in the SIPO (bit 0 = start, bit 9 = stop).
  function automatic frame_kind_e frame_classify(input logic [FRAME_BITS-1:0] p);
    frame_kind_e k;
    if (p == {FRAME_BITS{1'b0}}) begin
      k = FR_BRK;
    end else if ((p[0] != START_BIT) || (p[FRAME_BITS-1] != STOP_BIT)) begin
      k = FR_BAD;
    end else begin
      k = FR_OK;
    end
    return k;
  endfunction

endpackage

// File: rtl/frame_rx_10b_if.sv
// Byte stream handshake between the receiver and its consumer.
interface frame_rx_10b_if;
  import frame_rx_pkg::*;

  logic [DATA_BITS-1:0] Rdata;
  logic                 Rvalid;
  logic                 Rready;

  modport master (output Rdata, output Rvalid, input Rready);
  modport slave  (input Rdata, input Rvalid, output Rready);
endinterface

// File: rtl/frame_rx_fifo.sv
// Small synchronous first-word-fall-through FIFO with registered storage.
// A push is accepted when full only if a pop happens on the same edge.
module frame_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty_s, full_s, pop_ok_s, push_ok_s;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok_s  = pop & ~empty_s;
  assign push_ok_s = push & (~full_s | pop_ok_s);

  assign empty = empty_s;
  assign full  = full_s;
  // Head is read straight from storage; zero when nothing is queued.
  assign rdata = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  // Next storage contents and pointers from accepted push/pop.
  always_comb begin
    mem_d = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/frame_rx_10b.sv
// Frame receiver behind a 10-bit SIPO: delineates start/8 data/stop frames,
// validates them, queues good bytes and reports framing errors, breaks and
// overruns with a saturating event counter.
module frame_rx_10b
  import frame_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Sdata,
  input  logic [FRAME_BITS-1:0] Pdata,
  input  logic                  en,
  frame_rx_10b_if.master        rx,
  output logic                  frame_err,
  output logic                  brk,
  output logic                  overrun,
  input  logic                  clr_err,
  output logic [CNT_W-1:0]      err_count,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rx_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic                  brk_q, brk_d;
  logic                  overrun_q, overrun_d;
  logic [CNT_W-1:0]      err_count_q, err_count_d;

  logic                  push_s, ferr_s, brk_s, drop_s, pop_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [DATA_BITS-1:0]  fifo_rdata_s;
  logic                  start_s;

  // A start bit is only honoured while enabled and idle or finishing a frame.
  assign start_s = en && (Sdata == START_BIT);

  // FSM state and bit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: hunt for a start bit, count nine more bits, check for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HUNT, CHECK: begin
        if (start_s) begin
          state_d = SHIFT;
          cnt_d   = 4'd1;
        end else begin
          state_d = HUNT;
          cnt_d   = 4'd0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
          cnt_d   = 4'd0;
        end else begin
          state_d = SHIFT;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM outputs: during CHECK the SIPO holds the whole frame; decide its fate.
  always_comb begin
    push_s = 1'b0;
    ferr_s = 1'b0;
    brk_s  = 1'b0;
    case (state_q)
      CHECK: begin
        case (frame_classify(Pdata))
          FR_OK:   push_s = 1'b1;
          FR_BAD:  ferr_s = 1'b1;
          FR_BRK:  brk_s  = 1'b1;
          default: push_s = 1'b0;
        endcase
      end
      default: push_s = 1'b0;
    endcase
  end

  assign pop_s  = rx.Rready & ~fifo_empty_s;
  // A push into a full FIFO is only lost when no pop frees a slot that edge.
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  frame_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (Pdata[DATA_BITS:1]),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next values of the error pulses, sticky overrun and saturating counter.
  always_comb begin
    frame_err_d = ferr_s;
    brk_d       = brk_s;
    if (clr_err) begin
      overrun_d   = 1'b0;
      err_count_d = {CNT_W{1'b0}};
    end else begin
      if (drop_s) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
      if ((ferr_s | brk_s | drop_s) && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CNT_ONE;
      end else begin
        err_count_d = err_count_q;
      end
    end
  end

  // Error flag and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      brk_q       <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      frame_err_q <= frame_err_d;
      brk_q       <= brk_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  assign rx.Rdata  = fifo_rdata_s;
  assign rx.Rvalid = ~fifo_empty_s;
  assign frame_err = frame_err_q;
  assign brk       = brk_q;
  assign overrun   = overrun_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != HUNT);

endmodule

// File: tb/tb_frame_rx_10b.sv
// Self-checking bench for frame_rx_10b: drives the serial line, models the
// SIPO, and compares the DUT every cycle against a frame/queue level model.
module tb_frame_rx_10b;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Sdata = 1'b1;
  logic       en = 1'b1;
  logic       clr_err = 1'b0;
  logic [9:0] pdata;
  logic       frame_err, brk, overrun, busy;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  frame_rx_10b_if rx_if ();

  frame_rx_10b #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .Sdata     (Sdata),
    .Pdata     (pdata),
    .en        (en),
    .rx        (rx_if),
    .frame_err (frame_err),
    .brk       (brk),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Upstream SIPO: newest bit enters at the top.
  always @(posedge clk or posedge reset) begin
    if (reset) pdata <= 10'h000;
    else       pdata <= {Sdata, pdata[9:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_nbits = 0;       // bits of the current frame collected so far
  logic [9:0] m_bits  = 10'h000; // m_bits[k] = k-th bit of the frame on the line
  logic [7:0] m_q[$];
  logic       m_ferr = 1'b0, m_brk = 1'b0, m_ovr = 1'b0;
  int         m_cnt = 0;

  task automatic model_reset();
    m_nbits = 0; m_bits = 10'h000; m_q.delete();
    m_ferr = 1'b0; m_brk = 1'b0; m_ovr = 1'b0; m_cnt = 0;
  endtask

  // Effect of the coming clock edge given the inputs now on the wires.
  task automatic model_edge();
    logic ev_f, ev_b, ev_o, do_push, do_pop;
    logic [7:0] byte_v;
    int sz;
    ev_f = 1'b0; ev_b = 1'b0; ev_o = 1'b0; do_push = 1'b0; byte_v = 8'h00;
    sz = m_q.size();
    do_pop = rx_if.Rready && (sz > 0);
    if (m_nbits == 10) begin
      if (m_bits == 10'h000) ev_b = 1'b1;
      else if (m_bits[0] != 1'b0 || m_bits[9] != 1'b1) ev_f = 1'b1;
      else begin
        do_push = 1'b1;
        for (int k = 0; k < 8; k++) byte_v[k] = m_bits[k+1];
      end
      m_nbits = 0;
      if (en && !Sdata) begin m_bits[0] = 1'b0; m_nbits = 1; end
    end else if (m_nbits > 0) begin
      m_bits[m_nbits] = Sdata;
      m_nbits++;
    end else if (en && !Sdata) begin
      m_bits[0] = 1'b0;
      m_nbits = 1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (sz < DEPTH || do_pop) m_q.push_back(byte_v);
      else ev_o = 1'b1;
    end
    m_ferr = ev_f;
    m_brk  = ev_b;
    if (clr_err) begin
      m_ovr = 1'b0; m_cnt = 0;
    end else begin
      if (ev_o) m_ovr = 1'b1;
      if ((ev_f || ev_b || ev_o) && m_cnt < 255) m_cnt++;
    end
  endtask

  // Compare on the falling edge, then advance the model to the next edge.
  always @(negedge clk) begin
    if (reset) model_reset();
    chk("Rvalid",    32'(rx_if.Rvalid), 32'(m_q.size() > 0));
    chk("Rdata",     32'(rx_if.Rdata),  32'((m_q.size() > 0) ? m_q[0] : 8'h00));
    chk("frame_err", 32'(frame_err),    32'(m_ferr));
    chk("brk",       32'(brk),          32'(m_brk));
    chk("overrun",   32'(overrun),      32'(m_ovr));
    chk("err_count", 32'(err_count),    32'(m_cnt));
    chk("busy",      32'(busy),         32'(m_nbits != 0));
    if (!reset) model_edge();
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic s);
    Sdata = s;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    tick(1'b0);
    for (int i = 0; i < 8; i++) tick(d[i]);
    tick(stop);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_rvalid"},  32'(rx_if.Rvalid), 32'd0);
    chk({tag, "_rdata"},   32'(rx_if.Rdata),  32'h00);
    chk({tag, "_ferr"},    32'(frame_err),    32'd0);
    chk({tag, "_brk"},     32'(brk),          32'd0);
    chk({tag, "_ovr"},     32'(overrun),      32'd0);
    chk({tag, "_errcnt"},  32'(err_count),    32'd0);
    chk({tag, "_busy"},    32'(busy),         32'd0);
  endtask

  initial begin
    rx_if.Rready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_vals("por");
    reset = 1'b0;
    tick(1'b1); tick(1'b1);

    // Clean frame 0xA5.
    send_frame(8'hA5, 1'b1);
    chk("a5_pdata", 32'(pdata), 32'(10'b1101001010));
    chk("a5_busy_check", 32'(busy), 32'd1);
    tick(1'b1);
    chk("a5_rdata", 32'(rx_if.Rdata), 32'hA5);
    chk("a5_rvalid", 32'(rx_if.Rvalid), 32'd1);
    chk("a5_noerr", 32'({frame_err, brk}), 32'd0);
    rx_if.Rready = 1'b1;
    tick(1'b1);
    chk("a5_popped", 32'(rx_if.Rvalid), 32'd0);

    // Back-to-back 0x00 then 0xFF, consumer always ready.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(1'b1);
    chk("b2b_rdata", 32'(rx_if.Rdata), 32'hFF);
    chk("b2b_errcnt", 32'(err_count), 32'd0);
    tick(1'b1);

    // Bad stop bit, then a break.
    send_frame(8'h3C, 1'b0);
    tick(1'b1);
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_cnt", 32'(err_count), 32'd1);
    chk("ferr_nopush", 32'(rx_if.Rvalid), 32'd0);
    tick(1'b1);
    chk("ferr_end", 32'(frame_err), 32'd0);
    send_frame(8'h00, 1'b0);
    tick(1'b1);
    chk("brk_pulse", 32'(brk), 32'd1);
    chk("brk_cnt", 32'(err_count), 32'd2);
    chk("brk_noferr", 32'(frame_err), 32'd0);

    // Overrun: five frames into a four-entry FIFO with no consumer.
    clr_err = 1'b1; tick(1'b1); clr_err = 1'b0;
    chk("clr1_cnt", 32'(err_count), 32'd0);
    rx_if.Rready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      tick(1'b1);
    end
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_cnt", 32'(err_count), 32'd1);
    rx_if.Rready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_drain", 32'(rx_if.Rdata), 32'(i));
      tick(1'b1);
    end
    rx_if.Rready = 1'b0;
    chk("ovr_empty", 32'(rx_if.Rvalid), 32'd0);
    clr_err = 1'b1; tick(1'b1); clr_err = 1'b0;
    chk("clr2_ovr", 32'(overrun), 32'd0);
    chk("clr2_cnt", 32'(err_count), 32'd0);

    // Full FIFO with a pop on the push edge: no overrun.
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1);
      tick(1'b1);
    end
    send_frame(8'h05, 1'b1);
    rx_if.Rready = 1'b1;
    tick(1'b1);
    rx_if.Rready = 1'b0;
    chk("fullpop_ovr", 32'(overrun), 32'd0);
    chk("fullpop_head", 32'(rx_if.Rdata), 32'h02);
    rx_if.Rready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_drain", 32'(rx_if.Rdata), 32'(i));
      tick(1'b1);
    end
    rx_if.Rready = 1'b0;

    // en dropped mid-frame: frame completes, then the block stays idle.
    begin
      logic [7:0] d;
      d = 8'h66;
      tick(1'b0);
      for (int i = 0; i < 8; i++) begin
        if (i == 2) en = 1'b0;
        tick(d[i]);
      end
      tick(1'b1);
    end
    repeat (4) tick(1'b0);
    chk("en_idle_busy", 32'(busy), 32'd0);
    chk("en_rdata", 32'(rx_if.Rdata), 32'h66);
    tick(1'b1);
    en = 1'b1;
    tick(1'b1);

    // Counter saturation under 300 bad frames.
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h3C, 1'b0);
      tick(1'b1);
    end
    chk("sat_cnt", 32'(err_count), 32'hFF);

    // Asynchronous reset in the middle of a frame.
    tick(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1);
    reset = 1'b1;
    #1;
    reset_vals("midrst");
    #1;
    tick(1'b1);
    reset = 1'b0;
    tick(1'b1);
    send_frame(8'h5A, 1'b1);
    tick(1'b1);
    chk("post_rst_rdata", 32'(rx_if.Rdata), 32'h5A);
    chk("post_rst_rvalid", 32'(rx_if.Rvalid), 32'd1);
    chk("post_rst_cnt", 32'(err_count), 32'd0);
    repeat (3) tick(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
